// File: rtl/thee_bus_deskew.sv
// Deskewing receiver: synchronizes a skewed bus and commits it only after every bit has settled.
// Tracks intermediate transitions and forces a commit when the bus never settles.
module thee_bus_deskew #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_SETTLE    = 64,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             clr_timeout,
    output logic [WIDTH-1:0] bus_out,
    output logic             upd,
    output logic             settling,
    output logic             timeout,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int unsigned StabW   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SettleW = $clog2(MAX_SETTLE + 1);
    localparam logic [StabW-1:0]   StabMax   = StabW'(STABLE_CYCLES);
    localparam logic [SettleW-1:0] SettleMax = SettleW'(MAX_SETTLE);

    typedef enum logic [0:0] {StStable, StSettle} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   d, d_prev_q;
    logic [StabW-1:0]   stab_q, stab_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [WIDTH-1:0]   bus_out_q, bus_out_d;
    logic               upd_q, upd_d;
    logic               settling_q;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   glitch_q, glitch_d;

    assign d = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        settle_d  = settle_q;
        bus_out_d = bus_out_q;
        upd_d     = 1'b0;
        timeout_d = timeout_q;
        glitch_d  = glitch_q;

        if (clr_timeout) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            StStable: begin
                if (d != bus_out_q) begin
                    state_d  = StSettle;
                    stab_d   = StabW'(1);
                    settle_d = SettleW'(1);
                end
            end
            StSettle: begin
                if (d != d_prev_q) begin
                    stab_d = StabW'(1);
                    if (glitch_q != '1) begin
                        glitch_d = glitch_q + CNT_W'(1);
                    end
                end else if (stab_q < StabMax) begin
                    stab_d = stab_q + StabW'(1);
                end
                if (settle_q < SettleMax) begin
                    settle_d = settle_q + SettleW'(1);
                end

                // A normal commit takes priority over the forced one on the same edge.
                if (stab_d == StabMax) begin
                    state_d = StStable;
                    if (d != bus_out_q) begin
                        bus_out_d = d;
                        upd_d     = 1'b1;
                    end
                end else if (settle_q == SettleMax) begin
                    state_d   = StStable;
                    bus_out_d = d;
                    upd_d     = (d != bus_out_q);
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StStable;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StStable;
            d_prev_q   <= '0;
            stab_q     <= '0;
            settle_q   <= '0;
            bus_out_q  <= '0;
            upd_q      <= 1'b0;
            settling_q <= 1'b0;
            timeout_q  <= 1'b0;
            glitch_q   <= '0;
        end else begin
            state_q    <= state_d;
            d_prev_q   <= d;
            stab_q     <= stab_d;
            settle_q   <= settle_d;
            bus_out_q  <= bus_out_d;
            upd_q      <= upd_d;
            settling_q <= (state_d == StSettle);
            timeout_q  <= timeout_d;
            glitch_q   <= glitch_d;
        end
    end

    assign bus_out    = bus_out_q;
    assign upd        = upd_q;
    assign settling   = settling_q;
    assign timeout    = timeout_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_thee_bus_deskew.sv
// Directed bench for thee_bus_deskew: edge 0 is the edge after which bus_in is driven,
// so the first sampling edge is edge 1 and a clean commit lands on edge 6.
module tb_thee_bus_deskew;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bus_in;
    logic        clr_timeout;
    logic [7:0]  bus_out;
    logic        upd, settling, timeout;
    logic [15:0] glitch_cnt;
    logic [7:0]  s_bus_out;
    logic        s_upd, s_settling, s_timeout;
    logic [3:0]  s_glitch;

    int tests = 0;
    int fails = 0;

    thee_bus_deskew dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .clr_timeout(clr_timeout),
        .bus_out    (bus_out),
        .upd        (upd),
        .settling   (settling),
        .timeout    (timeout),
        .glitch_cnt (glitch_cnt)
    );

    thee_bus_deskew #(.CNT_W(4)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .clr_timeout(clr_timeout),
        .bus_out    (s_bus_out),
        .upd        (s_upd),
        .settling   (s_settling),
        .timeout    (s_timeout),
        .glitch_cnt (s_glitch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus_in      = 8'h00;
        clr_timeout = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus_in      = 8'h3C;
        clr_timeout = 1'b0;
        tick();
        tick();
        tests++;
        if ({bus_out, upd, settling, timeout, glitch_cnt} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs got bus=%h upd=%b set=%b to=%b gc=%0d want all 0",
                     bus_out, upd, settling, timeout, glitch_cnt);
        end
        bus_in = 8'h00;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            tests++;
            if ({bus_out, upd, settling} !== 10'd0) begin
                fails++;
                $display("FAIL reset_idle e=%0d got bus=%h upd=%b set=%b want 0", e, bus_out, upd,
                         settling);
            end
        end
    endtask

    task automatic test_clean();
        do_reset();
        bus_in = 8'hA5;
        for (int e = 1; e <= 9; e++) begin
            tick();
            tests += 3;
            if (upd !== (e == 6)) begin
                fails++;
                $display("FAIL clean_upd e=%0d got %b want %b", e, upd, (e == 6));
            end
            if (bus_out !== ((e >= 6) ? 8'hA5 : 8'h00)) begin
                fails++;
                $display("FAIL clean_bus e=%0d got %h want %h", e, bus_out,
                         ((e >= 6) ? 8'hA5 : 8'h00));
            end
            if (settling !== (e >= 3 && e <= 5)) begin
                fails++;
                $display("FAIL clean_settling e=%0d got %b want %b", e, settling,
                         (e >= 3 && e <= 5));
            end
        end
        tests += 2;
        if (glitch_cnt !== 16'd0) begin
            fails++;
            $display("FAIL clean_glitch got %0d want 0", glitch_cnt);
        end
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL clean_timeout got %b want 0", timeout);
        end
    endtask

    task automatic test_skew();
        int n_upd;
        n_upd = 0;
        do_reset();
        bus_in = 8'h05;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (upd === 1'b1) n_upd++;
            tests += 2;
            if (upd !== (e == 8)) begin
                fails++;
                $display("FAIL skew_upd e=%0d got %b want %b", e, upd, (e == 8));
            end
            if (bus_out !== 8'h00 && bus_out !== 8'hA5) begin
                fails++;
                $display("FAIL skew_partial e=%0d got %h want 00 or a5", e, bus_out);
            end
            if (e == 1) bus_in = 8'h25;
            if (e == 2) bus_in = 8'hA5;
        end
        tests += 3;
        if (n_upd != 1) begin
            fails++;
            $display("FAIL skew_upd_count got %0d want 1", n_upd);
        end
        if (bus_out !== 8'hA5) begin
            fails++;
            $display("FAIL skew_bus got %h want a5", bus_out);
        end
        if (glitch_cnt !== 16'd2) begin
            fails++;
            $display("FAIL skew_glitch got %0d want 2", glitch_cnt);
        end
    endtask

    task automatic test_excursion();
        do_reset();
        bus_in = 8'h01;
        for (int e = 1; e <= 12; e++) begin
            tick();
            tests += 2;
            if (upd !== 1'b0) begin
                fails++;
                $display("FAIL excursion_upd e=%0d got %b want 0", e, upd);
            end
            if (settling !== (e >= 3 && e <= 7)) begin
                fails++;
                $display("FAIL excursion_settling e=%0d got %b want %b", e, settling,
                         (e >= 3 && e <= 7));
            end
            if (e == 2) bus_in = 8'h00;
        end
        tests += 2;
        if (bus_out !== 8'h00) begin
            fails++;
            $display("FAIL excursion_bus got %h want 00", bus_out);
        end
        if (glitch_cnt !== 16'd1) begin
            fails++;
            $display("FAIL excursion_glitch got %0d want 1", glitch_cnt);
        end
    endtask

    // Bit 0 toggles every cycle: SETTLE entered at edge 3, forced commit at 67; re-entry at 68,
    // second forced commit at 132 with clr_timeout applied on that same edge.
    task automatic test_timeout();
        do_reset();
        bus_in = 8'h01;
        for (int e = 1; e <= 132; e++) begin
            tick();
            tests++;
            if (upd !== (e == 67 || e == 132)) begin
                fails++;
                $display("FAIL timeout_upd e=%0d got %b want %b", e, upd, (e == 67 || e == 132));
            end
            if (e == 66) begin
                tests += 2;
                if (timeout !== 1'b0 || settling !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_pre e=%0d got to=%b set=%b want to=0 set=1", e,
                             timeout, settling);
                end
                if (glitch_cnt !== 16'd63) begin
                    fails++;
                    $display("FAIL timeout_glitch_pre got %0d want 63", glitch_cnt);
                end
            end
            if (e == 67) begin
                tests += 3;
                if (timeout !== 1'b1 || settling !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_force e=%0d got to=%b set=%b want to=1 set=0", e,
                             timeout, settling);
                end
                if (bus_out !== 8'h01) begin
                    fails++;
                    $display("FAIL timeout_force_bus got %h want 01", bus_out);
                end
                if (glitch_cnt !== 16'd64) begin
                    fails++;
                    $display("FAIL timeout_glitch got %0d want 64", glitch_cnt);
                end
            end
            if (e == 68 || e == 131) begin
                tests++;
                if (timeout !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_clear e=%0d got %b want 0", e, timeout);
                end
            end
            if (e == 132) begin
                tests += 3;
                if (timeout !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_set_wins got %b want 1", timeout);
                end
                if (bus_out !== 8'h00) begin
                    fails++;
                    $display("FAIL timeout_force2_bus got %h want 00", bus_out);
                end
                if (glitch_cnt !== 16'd128) begin
                    fails++;
                    $display("FAIL timeout_glitch2 got %0d want 128", glitch_cnt);
                end
            end
            bus_in      = (e % 2 == 0) ? 8'h01 : 8'h00;
            clr_timeout = (e == 67 || e == 131);
        end
        clr_timeout = 1'b0;
    endtask

    // 21 driven values alternate 1/0 ending on 1: glitches on edges 4..23, commit at 26.
    task automatic test_saturation();
        do_reset();
        bus_in = 8'h01;
        for (int e = 1; e <= 30; e++) begin
            tick();
            tests++;
            if (upd !== (e == 26)) begin
                fails++;
                $display("FAIL sat_upd e=%0d got %b want %b", e, upd, (e == 26));
            end
            if (e == 18) begin
                tests++;
                if (s_glitch !== 4'd15) begin
                    fails++;
                    $display("FAIL sat_reach got %0d want 15", s_glitch);
                end
            end
            if (e <= 20) bus_in = (e % 2 == 0) ? 8'h01 : 8'h00;
        end
        tests += 4;
        if (s_glitch !== 4'd15) begin
            fails++;
            $display("FAIL sat_hold got %0d want 15", s_glitch);
        end
        if (glitch_cnt !== 16'd20) begin
            fails++;
            $display("FAIL sat_wide got %0d want 20", glitch_cnt);
        end
        if (bus_out !== 8'h01 || s_bus_out !== 8'h01) begin
            fails++;
            $display("FAIL sat_bus got %h/%h want 01/01", bus_out, s_bus_out);
        end
        if ({s_upd, s_settling, s_timeout} !== 3'b000) begin
            fails++;
            $display("FAIL sat_small_flags got %b want 000", {s_upd, s_settling, s_timeout});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_in = 8'hFF;
        for (int e = 1; e <= 13; e++) begin
            tick();
            tests++;
            if (upd !== (e == 11)) begin
                fails++;
                $display("FAIL rstmid_upd e=%0d got %b want %b", e, upd, (e == 11));
            end
            if (e == 4) begin
                tests++;
                if (settling !== 1'b1) begin
                    fails++;
                    $display("FAIL rstmid_settling got %b want 1", settling);
                end
                rst = 1'b1;
            end
            if (e == 5) begin
                tests++;
                if ({bus_out, upd, settling, timeout, glitch_cnt} !== 27'd0) begin
                    fails++;
                    $display("FAIL rstmid_outputs got bus=%h upd=%b set=%b to=%b gc=%0d want 0",
                             bus_out, upd, settling, timeout, glitch_cnt);
                end
                rst = 1'b0;
            end
            if (e == 11) begin
                tests++;
                if (bus_out !== 8'hFF) begin
                    fails++;
                    $display("FAIL rstmid_bus got %h want ff", bus_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_skew();
        test_excursion();
        test_timeout();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
